// File: rtl/div_nr_param.sv
// Parametrised multi-cycle non-restoring divider for the MIPS EX stage.
// Serves DIV (signed) and DIVU (unsigned). Operands are captured when start
// is seen while idle. Divide-by-zero and signed MIN/-1 finish on the capture
// edge. Every other operation finishes WIDTH+1 falling edges after capture.
// All state updates on the falling edge of clock. Reset is asynchronous and
// active-high.

module div_nr_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] MIN_VAL    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             signedOp_q, signedOp_d;
  logic             dividendNeg_q, dividendNeg_d;
  logic             divisorNeg_q, divisorNeg_d;
  logic [WIDTH-1:0] divisorMag_q, divisorMag_d;
  logic [WIDTH:0]   partRem_q, partRem_d;
  logic [WIDTH-1:0] quotAcc_q, quotAcc_d;
  logic [WIDTH-1:0] qOut_q, qOut_d;
  logic [WIDTH-1:0] rOut_q, rOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divZero_q, divZero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] dividendMag;
  logic [WIDTH-1:0] divisorMag;
  logic             isDivZero;
  logic             isOverflow;
  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] fixRem;
  logic             negQuot;
  logic             negRem;
  logic [WIDTH-1:0] finalQ;
  logic [WIDTH-1:0] finalR;

  // Operand magnitudes and special-case detection on the live inputs.
  // The quotient accumulator starts out holding the dividend magnitude.
  // Its MSB feeds the remainder on each shift.
  assign dividendMag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisorMag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign isDivZero   = (divisor == '0);
  assign isOverflow  = is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES);

  // One non-restoring step in WIDTH+1 bits. Dropping the old sign bit in
  // the shift is safe because the partial remainder always lies in
  // [-divisor, divisor).
  assign shiftedRem = {partRem_q[WIDTH-1:0], quotAcc_q[WIDTH-1]};
  assign stepRem    = partRem_q[WIDTH] ? (shiftedRem + {1'b0, divisorMag_q})
                                       : (shiftedRem - {1'b0, divisorMag_q});

  // Final restore and sign correction. The restored remainder fits in WIDTH
  // bits, so the add is done at that width.
  assign fixRem  = partRem_q[WIDTH-1:0] + (partRem_q[WIDTH] ? divisorMag_q : '0);
  assign negQuot = signedOp_q & (dividendNeg_q ^ divisorNeg_q);
  assign negRem  = signedOp_q & dividendNeg_q;
  assign finalQ  = negQuot ? -quotAcc_q : quotAcc_q;
  assign finalR  = negRem  ? -fixRem    : fixRem;

  // Next-state and datapath decisions. start is only honoured in IDLE.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    signedOp_d    = signedOp_q;
    dividendNeg_d = dividendNeg_q;
    divisorNeg_d  = divisorNeg_q;
    divisorMag_d  = divisorMag_q;
    partRem_d     = partRem_q;
    quotAcc_d     = quotAcc_q;
    qOut_d        = qOut_q;
    rOut_d        = rOut_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    divZero_d     = divZero_q;
    overflow_d    = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (isDivZero) begin
            qOut_d     = ALL_ONES;
            rOut_d     = dividend;
            divZero_d  = 1'b1;
            overflow_d = 1'b0;
            done_d     = 1'b1;
          end else if (isOverflow) begin
            qOut_d     = MIN_VAL;
            rOut_d     = '0;
            divZero_d  = 1'b0;
            overflow_d = 1'b1;
            done_d     = 1'b1;
          end else begin
            signedOp_d    = is_signed;
            dividendNeg_d = is_signed & dividend[WIDTH-1];
            divisorNeg_d  = is_signed & divisor[WIDTH-1];
            divisorMag_d  = divisorMag;
            quotAcc_d     = dividendMag;
            partRem_d     = '0;
            count_d       = '0;
            busy_d        = 1'b1;
            state_d       = ITER;
          end
        end
      end

      ITER: begin
        partRem_d = stepRem;
        quotAcc_d = {quotAcc_q[WIDTH-2:0], ~stepRem[WIDTH]};
        if (count_q == LAST_COUNT) begin
          count_d = '0;
          state_d = FIX;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      FIX: begin
        qOut_d     = finalQ;
        rOut_d     = finalR;
        divZero_d  = 1'b0;
        overflow_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers. Update on the falling edge, clear on reset.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      signedOp_q    <= 1'b0;
      dividendNeg_q <= 1'b0;
      divisorNeg_q  <= 1'b0;
      divisorMag_q  <= '0;
      partRem_q     <= '0;
      quotAcc_q     <= '0;
      qOut_q        <= '0;
      rOut_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      divZero_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      signedOp_q    <= signedOp_d;
      dividendNeg_q <= dividendNeg_d;
      divisorNeg_q  <= divisorNeg_d;
      divisorMag_q  <= divisorMag_d;
      partRem_q     <= partRem_d;
      quotAcc_q     <= quotAcc_d;
      qOut_q        <= qOut_d;
      rOut_q        <= rOut_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      divZero_q     <= divZero_d;
      overflow_q    <= overflow_d;
    end
  end

  assign q        = qOut_q;
  assign r        = rOut_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = divZero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_div_nr_param.sv
// Self-checking bench for div_nr_param at WIDTH=32 and WIDTH=8.
// Inputs are driven, and outputs sampled, on the rising edge, away from the
// falling edge on which the design updates.

module tb_div_nr_param;

  logic        clock;
  logic        reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32, q32, r32;
  logic        busy32, done32, dz32, ov32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8, q8, r8;
  logic        busy8, done8, dz8, ov8;

  int total;
  int bad;

  typedef struct packed {
    logic [63:0] q;
    logic [63:0] r;
    logic        busy;
    logic        done;
    logic        dz;
    logic        ov;
  } obs_t;

  div_nr_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .is_signed(sgn32),
    .dividend(a32), .divisor(b32), .q(q32), .r(r32), .busy(busy32),
    .done(done32), .div_zero(dz32), .overflow(ov32)
  );

  div_nr_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
    .dividend(a8), .divisor(b8), .q(q8), .r(r8), .busy(busy8),
    .done(done8), .div_zero(dz8), .overflow(ov8)
  );

  // Free-running clock with the active falling edge at 5, 15, 25, ...
  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Hard limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input longint unsigned got,
                             input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample(input int w);
    obs_t o;
    if (w == 8) begin
      o.q = 64'(q8); o.r = 64'(r8);
      o.busy = busy8; o.done = done8; o.dz = dz8; o.ov = ov8;
    end else begin
      o.q = 64'(q32); o.r = 64'(r32);
      o.busy = busy32; o.done = done32; o.dz = dz32; o.ov = ov32;
    end
    return o;
  endfunction

  task automatic drive(input int w, input bit st, input bit sgn,
                       input longint unsigned a, input longint unsigned b);
    if (w == 8) begin
      start8 = st; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = st; sgn32 = sgn; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  // Reference result from plain integer arithmetic. SystemVerilog signed
  // division truncates toward zero, and % takes the sign of the dividend.
  function automatic void refDiv(input int w, input bit sgn,
                                 input longint unsigned a, input longint unsigned b,
                                 output longint unsigned eq, output longint unsigned er,
                                 output bit edz, output bit eov);
    longint unsigned mask, half, ua, ub;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    ua = a & mask;
    ub = b & mask;
    edz = 1'b0;
    eov = 1'b0;
    if (ub == 64'd0) begin
      eq = mask; er = ua; edz = 1'b1;
    end else if (sgn) begin
      sa = ((ua & half) != 64'd0) ? (longint'(ua) - longint'(mask + 64'd1)) : longint'(ua);
      sb = ((ub & half) != 64'd0) ? (longint'(ub) - longint'(mask + 64'd1)) : longint'(ub);
      if ((sa == -longint'(half)) && (sb == -64'sd1)) begin
        eq = ua; er = 64'd0; eov = 1'b1;
      end else begin
        eq = longint'(sa / sb) & mask;
        er = longint'(sa % sb) & mask;
      end
    end else begin
      eq = ua / ub;
      er = ua % ub;
    end
  endfunction

  // Issue one operation, scramble the inputs after capture, and wait
  // (bounded) for done. Then check latency, busy span, results and flags.
  task automatic applyStimulus(input int w, input bit sgn, input longint unsigned a,
                               input longint unsigned b, input string tag);
    longint unsigned eq, er;
    bit   edz, eov, seen;
    int   n, busyCnt, expLat;
    obs_t o;
    refDiv(w, sgn, a, b, eq, er, edz, eov);
    expLat = (edz || eov) ? 0 : w + 1;
    @(posedge clock);
    drive(w, 1'b1, sgn, a, b);
    @(posedge clock);
    drive(w, 1'b0, ~sgn, 64'($urandom), 64'($urandom));
    n = 0; busyCnt = 0; seen = 1'b0;
    while (!seen && n <= w + 5) begin
      o = sample(w);
      if (o.done) seen = 1'b1;
      else begin
        if (o.busy) busyCnt++;
        n++;
        @(posedge clock);
      end
    end
    o = sample(w);
    checkOutput({tag, ".done"},       64'(seen),    64'd1);
    checkOutput({tag, ".latency"},    64'(n),       64'(expLat));
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(expLat));
    checkOutput({tag, ".busyAtDone"}, 64'(o.busy),  64'd0);
    checkOutput({tag, ".q"},          o.q,          eq);
    checkOutput({tag, ".r"},          o.r,          er);
    checkOutput({tag, ".divZero"},    64'(o.dz),    64'(edz));
    checkOutput({tag, ".overflow"},   64'(o.ov),    64'(eov));
    @(posedge clock);
    o = sample(w);
    checkOutput({tag, ".donePulse"},  64'(o.done),  64'd0);
    checkOutput({tag, ".qHeld"},      o.q,          eq);
  endtask

  initial begin
    obs_t o;
    int   doneCnt, firstLat, n;
    bit   seen;
    longint unsigned a, b, mask, eq, er;
    bit   sgn, edz, eov;
    int   w, mode;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(8,  1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clock);

    // Reset state of both instances.
    o = sample(32);
    checkOutput("reset32.q",    o.q, 64'd0);
    checkOutput("reset32.r",    o.r, 64'd0);
    checkOutput("reset32.flags", 64'({o.busy, o.done, o.dz, o.ov}), 64'd0);
    o = sample(8);
    checkOutput("reset8.qr",    o.q | o.r, 64'd0);
    checkOutput("reset8.flags", 64'({o.busy, o.done, o.dz, o.ov}), 64'd0);
    reset = 1'b0;

    // Directed operations.
    applyStimulus(32, 1'b0, 64'd7, 64'd2, "u7div2");
    checkOutput("u7div2.qConst", 64'(q32), 64'd3);
    checkOutput("u7div2.rConst", 64'(r32), 64'd1);
    applyStimulus(32, 1'b1, 64'hFFFF_FFF9, 64'd2, "s-7div2");
    applyStimulus(32, 1'b0, 64'hFFFF_FFF9, 64'd2, "u-7div2");
    checkOutput("u-7div2.qConst", 64'(q32), 64'h7FFF_FFFC);
    applyStimulus(32, 1'b0, 64'd5, 64'd0, "u5div0");
    applyStimulus(32, 1'b1, 64'hFFFF_FFFB, 64'd0, "s-5div0");
    applyStimulus(32, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, "sMinOvf");
    applyStimulus(32, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF, "uMinNoOvf");
    applyStimulus(32, 1'b1, 64'd7, 64'hFFFF_FFFE, "s7divm2");
    applyStimulus(32, 1'b1, 64'hFFFF_FFF9, 64'hFFFF_FFFE, "sm7divm2");
    applyStimulus(8,  1'b1, 64'h80, 64'h03, "w8sMin3");
    checkOutput("w8sMin3.qConst", 64'(q8), 64'hD6);
    checkOutput("w8sMin3.rConst", 64'(r8), 64'hFE);
    applyStimulus(8,  1'b0, 64'hFF, 64'h10, "w8uFF10");
    applyStimulus(8,  1'b1, 64'h80, 64'hFF, "w8ovf");

    // Operand changes and a start pulse during an operation must not disturb it.
    @(posedge clock);
    drive(32, 1'b1, 1'b0, 64'd100, 64'd7);
    @(posedge clock);
    drive(32, 1'b0, 1'b1, 64'hDEAD_BEEF, 64'd3);
    doneCnt = 0; firstLat = -1;
    for (int k = 0; k < 80; k++) begin
      o = sample(32);
      if (o.done) begin
        doneCnt++;
        if (firstLat < 0) firstLat = k;
      end
      if (k == 9)  drive(32, 1'b1, 1'b1, 64'd50, 64'd0);
      if (k == 10) drive(32, 1'b0, 1'b0, 64'd1, 64'd1);
      @(posedge clock);
    end
    o = sample(32);
    checkOutput("interf.doneCount", 64'(doneCnt), 64'd1);
    checkOutput("interf.latency",   64'(firstLat), 64'd33);
    checkOutput("interf.q",         o.q, 64'd14);
    checkOutput("interf.r",         o.r, 64'd2);
    checkOutput("interf.divZero",   64'(o.dz), 64'd0);

    // Reset in the middle of an operation discards it.
    @(posedge clock);
    drive(32, 1'b1, 1'b0, 64'd1000, 64'd9);
    @(posedge clock);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (14) @(posedge clock);
    reset = 1'b1;
    #1;
    o = sample(32);
    checkOutput("midReset.busy",  64'(o.busy), 64'd0);
    checkOutput("midReset.qr",    o.q | o.r,   64'd0);
    checkOutput("midReset.flags", 64'({o.done, o.dz, o.ov}), 64'd0);
    @(posedge clock);
    reset = 1'b0;
    doneCnt = 0;
    repeat (45) begin
      @(posedge clock);
      o = sample(32);
      if (o.done || o.busy) doneCnt++;
    end
    checkOutput("midReset.noDone", 64'(doneCnt), 64'd0);
    applyStimulus(32, 1'b0, 64'd1000, 64'd9, "afterReset");

    // start held high: refused on the done edge, accepted on the next one.
    refDiv(8, 1'b0, 64'd200, 64'd7, eq, er, edz, eov);
    @(posedge clock);
    drive(8, 1'b1, 1'b0, 64'd200, 64'd7);
    @(posedge clock);
    n = 0; seen = 1'b0;
    while (!seen && n <= 20) begin
      o = sample(8);
      if (o.done) seen = 1'b1;
      else begin n++; @(posedge clock); end
    end
    checkOutput("b2b.first.latency", 64'(n), 64'd9);
    checkOutput("b2b.first.busy",    64'(o.busy), 64'd0);
    checkOutput("b2b.first.q",       o.q, eq);
    checkOutput("b2b.first.r",       o.r, er);
    drive(8, 1'b1, 1'b0, 64'd100, 64'd9);
    @(posedge clock);
    o = sample(8);
    checkOutput("b2b.accepted", 64'(o.busy), 64'd1);
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    refDiv(8, 1'b0, 64'd100, 64'd9, eq, er, edz, eov);
    n = 0; seen = 1'b0;
    while (!seen && n <= 20) begin
      o = sample(8);
      if (o.done) seen = 1'b1;
      else begin n++; @(posedge clock); end
    end
    checkOutput("b2b.second.latency", 64'(n), 64'd9);
    checkOutput("b2b.second.q",       o.q, eq);
    checkOutput("b2b.second.r",       o.r, er);

    // Randomised operations on both widths, biased toward the special cases.
    for (int i = 0; i < 60; i++) begin
      w    = (i % 2 == 1) ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      sgn  = 1'($urandom_range(0, 1));
      a    = 64'($urandom);
      b    = 64'($urandom);
      mode = int'($urandom_range(0, 7));
      if (mode == 0) b = 64'd0;
      else if (mode == 1) begin
        sgn = 1'b1;
        a   = 64'd1 << (w - 1);
        b   = mask;
      end else if (mode == 2) b = 64'($urandom_range(1, 15));
      applyStimulus(w, sgn, a & mask, b & mask, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
